// File: rtl/scroll_display.sv
// Binary value to BCD with an iterative shift-add-3 converter, shown through a windowed/scrolling/blinking digit view.
// Optional: define SCROLL_DISPLAY_LZB_EN to blank leading zero digits.
module scroll_display #(
  parameter int DATA_W     = 10,
  parameter int NUM_DIGITS = 4,
  parameter int WIN_DIGITS = 2,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [DATA_W-1:0]       value,
  input  logic                    load,
  input  logic [1:0]              mode,
  output logic [4*WIN_DIGITS-1:0] win_bcd,
  output logic [WIN_DIGITS-1:0]   win_blank,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] M_OFF    = 2'd0;
  localparam logic [1:0] M_SCROLL = 2'd2;
  localparam logic [1:0] M_BLINK  = 2'd3;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  state_t              state;
  logic [DATA_W-1:0]   sh;
  logic [BW-1:0]       acc;
  logic [BW-1:0]       digits;
  logic [CW-1:0]       cnt;
  logic                ovf_pend;
  logic [PW-1:0]       ptr;
  logic                phase;
  logic [TW-1:0]       presc;

  logic                tick;
  logic                fin;
  logic                ld;
  logic                over;
  logic                conv_n;
  logic                show_n;
  logic [BW-1:0]       adj;
  logic [BW-1:0]       acc_sh;
  logic [BW-1:0]       digits_n;
  logic [PW-1:0]       ptr_n;
  logic                phase_n;
  logic [4*WIN_DIGITS-1:0] bcd_n;
  logic [WIN_DIGITS-1:0]   blank_n;

  assign tick   = (presc == TW'(TICK_DIV - 1));
  assign fin    = (state == CONV) && (cnt == CW'(DATA_W));
  assign ld     = load && (state != CONV);
  assign over   = (64'(value) >= LIMIT);
  assign conv_n = ld || ((state == CONV) && !fin);
  assign show_n = ((state == SHOW) && !ld) || fin;

  // One double-dabble step: fix up digits >= 5, then shift the next binary bit in.
  always_comb begin
    adj = acc;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    acc_sh = {adj[BW-2:0], sh[DATA_W-1]};
  end

  always_comb begin
    digits_n = digits;
    if (fin) digits_n = ovf_pend ? {NUM_DIGITS{4'h9}} : acc;

    ptr_n = '0;
    if (!fin && mode == M_SCROLL)
      ptr_n = tick ? ((ptr == PW'(NUM_DIGITS - 1)) ? '0 : ptr + 1'b1) : ptr;

    phase_n = phase;
    if (fin) phase_n = 1'b1;
    else if (mode == M_BLINK && tick) phase_n = ~phase;
  end

  // Window is built from next-edge state so outputs, pointer and digits move together.
  always_comb begin
    int j;
`ifdef SCROLL_DISPLAY_LZB_EN
    int msnz;
    msnz = 0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (digits_n[4*i +: 4] != 4'd0) msnz = i;
`endif
    bcd_n   = '0;
    blank_n = '1;
    for (int k = 0; k < WIN_DIGITS; k++) begin
      j = int'(ptr_n) + k;
      if (j >= NUM_DIGITS) j = j - NUM_DIGITS;
      bcd_n[4*k +: 4] = digits_n[4*j +: 4];
      if (show_n && mode != M_OFF && !(mode == M_BLINK && !phase_n)) begin
        blank_n[k] = 1'b0;
`ifdef SCROLL_DISPLAY_LZB_EN
        blank_n[k] = (j > msnz);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      sh        <= '0;
      acc       <= '0;
      digits    <= '0;
      cnt       <= '0;
      ovf_pend  <= 1'b0;
      ptr       <= '0;
      phase     <= 1'b1;
      presc     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      win_bcd   <= '0;
      win_blank <= '1;
    end else begin
      presc  <= tick ? '0 : presc + 1'b1;
      ptr    <= ptr_n;
      phase  <= phase_n;
      digits <= digits_n;
      done   <= fin;
      if (ld) begin
        sh       <= value;
        acc      <= '0;
        cnt      <= '0;
        ovf_pend <= over;
        busy     <= 1'b1;
        state    <= CONV;
      end else if (state == CONV) begin
        if (fin) begin
          busy  <= 1'b0;
          ovf   <= ovf_pend;
          state <= SHOW;
        end else begin
          acc <= acc_sh;
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
        end
      end
      if (!conv_n) begin
        win_bcd   <= bcd_n;
        win_blank <= blank_n;
      end
    end
  end

endmodule
